// File: rtl/calc_btn_cond.sv
// Push-button conditioner: four two-flop synchronizers, independent debounce
// channels, and a one-shot execute strobe plus a sticky op_valid on btnd presses.
module calc_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnl,
  input  logic btnc,
  input  logic btnr,
  input  logic btnd,
  output logic btnl_db,
  output logic btnc_db,
  output logic btnr_db,
  output logic btnd_db,
  output logic btnd_pulse,
  output logic op_valid
);

  localparam int NCH = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0=l, 1=c, 2=r, 3=d
  logic             raw      [NCH];
  logic             s1_q     [NCH];
  logic             s2_q     [NCH];
  logic             db_q     [NCH];
  logic             db_d     [NCH];
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_d    [NCH];
  logic             pulse_q;
  logic             pulse_d;
  logic             op_valid_q;
  logic             op_valid_d;

  assign raw[0] = btnl;
  assign raw[1] = btnc;
  assign raw[2] = btnr;
  assign raw[3] = btnd;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      always_comb begin
        cnt_d[gi] = '0;
        db_d[gi]  = db_q[gi];
        // Toggle on the last differing edge so the counter never exceeds CNT_LAST.
        if (s2_q[gi] != db_q[gi]) begin
          if (cnt_q[gi] == CNT_LAST) begin
            db_d[gi] = ~db_q[gi];
          end else begin
            cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q[gi]  <= 1'b0;
          s2_q[gi]  <= 1'b0;
          cnt_q[gi] <= '0;
          db_q[gi]  <= 1'b0;
        end else begin
          s1_q[gi]  <= raw[gi];
          s2_q[gi]  <= s1_q[gi];
          cnt_q[gi] <= cnt_d[gi];
          db_q[gi]  <= db_d[gi];
        end
      end
    end
  endgenerate

  // Strobe is registered alongside the debounced rise so both appear in the same cycle.
  always_comb begin
    pulse_d    = db_d[3] & ~db_q[3];
    op_valid_d = op_valid_q | pulse_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q    <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      pulse_q    <= pulse_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign btnl_db    = db_q[0];
  assign btnc_db    = db_q[1];
  assign btnr_db    = db_q[2];
  assign btnd_db    = db_q[3];
  assign btnd_pulse = pulse_q;
  assign op_valid   = op_valid_q;

endmodule

// File: tb/tb_calc_btn_cond.sv
// Bench for calc_btn_cond with DEBOUNCE_CYCLES=4: directed scenarios plus random
// button activity, checked every cycle against a history-based debounce model.
module tb_calc_btn_cond;

  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic btnl  = 1'b0;
  logic btnc  = 1'b0;
  logic btnr  = 1'b0;
  logic btnd  = 1'b0;
  logic btnl_db, btnc_db, btnr_db, btnd_db, btnd_pulse, op_valid;

  calc_btn_cond #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btnl       (btnl),
    .btnc       (btnc),
    .btnr       (btnr),
    .btnd       (btnd),
    .btnl_db    (btnl_db),
    .btnc_db    (btnc_db),
    .btnr_db    (btnr_db),
    .btnd_db    (btnd_db),
    .btnd_pulse (btnd_pulse),
    .op_valid   (op_valid)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Model: raw samples logged per edge since reset; the synchronized value seen at
  // edge j is the raw value sampled at edge j-2 (zero before that).
  bit raw_log [4][$];
  bit m_db    [4];
  int m_last  [4];
  int m_k;
  bit m_pulse;
  bit m_opv;

  function automatic bit syn_at(int c, int j);
    if (j < 2) return 1'b0;
    return raw_log[c][j-2];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      raw_log[c].delete();
      m_db[c]   = 1'b0;
      m_last[c] = -D;
    end
    m_k     = 0;
    m_pulse = 1'b0;
    m_opv   = 1'b0;
  endtask

  // A level flips at edge k when the last D synchronized samples all disagree with
  // it and at least D edges have passed since its previous flip.
  task automatic model_step();
    bit raw [4];
    bit stable;
    raw[0] = btnl; raw[1] = btnc; raw[2] = btnr; raw[3] = btnd;
    m_pulse = 1'b0;
    for (int c = 0; c < 4; c++) raw_log[c].push_back(raw[c]);
    for (int c = 0; c < 4; c++) begin
      if (m_k - m_last[c] >= D) begin
        stable = 1'b1;
        for (int j = m_k - D + 1; j <= m_k; j++)
          if (syn_at(c, j) == m_db[c]) stable = 1'b0;
        if (stable) begin
          m_db[c]   = ~m_db[c];
          m_last[c] = m_k;
          if (c == 3 && m_db[c]) m_pulse = 1'b1;
        end
      end
    end
    m_opv = m_opv | m_pulse;
    m_k++;
  endtask

  initial forever begin
    @(posedge clk);
    if (chk_en && rst_n) model_step();
  end

  initial forever begin
    logic [5:0] got, exp;
    @(negedge clk);
    if (chk_en) begin
      got = {op_valid, btnd_pulse, btnd_db, btnr_db, btnc_db, btnl_db};
      exp = {m_opv, m_pulse, m_db[3], m_db[2], m_db[1], m_db[0]};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t got={opv,pulse,d,r,c,l}=%b exp=%b", $time, got, exp);
      end
    end
  end

  task automatic check(string name, logic [5:0] got, logic [5:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {op_valid, btnd_pulse, btnd_db, btnr_db, btnc_db, btnl_db};
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset applied off the clock edges; the next posedge after release is E0.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_btns(logic [3:0] v);
    {btnd, btnr, btnc, btnl} = v;
  endtask

  initial begin
    int pulses, pcyc, dbcyc;
    int pat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

    // btnl held from E0: rises after E5, not before
    set_btns(4'b0001);
    do_reset();
    check("reset_state", outs(), 6'b000000);
    step(5);
    check("btnl_after_E4", outs(), 6'b000000);
    step(1);
    check("btnl_after_E5", outs(), 6'b000001);

    // btnc 3-clock glitch, then held: counter must restart
    set_btns(4'b0010);
    do_reset();
    step(3);
    btnc = 1'b0;
    step(1);
    btnc = 1'b1;
    check("btnc_glitch", outs(), 6'b000000);
    step(5);
    check("btnc_after_E8", outs(), 6'b000000);
    step(1);
    check("btnc_after_E9", outs(), 6'b000010);

    // btnd held 20 clocks then released: one pulse coincident with db rise
    set_btns(4'b1000);
    do_reset();
    pulses = 0; pcyc = -1; dbcyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (btnd_pulse) begin pulses++; pcyc = i; end
      if (btnd_db && dbcyc < 0) dbcyc = i;
    end
    btnd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (btnd_pulse) pulses++;
    end
    check_int("btnd_pulse_count", pulses, 1);
    check_int("btnd_pulse_edge", pcyc, 5);
    check_int("btnd_db_rise_edge", dbcyc, 5);
    check("btnd_released", outs(), 6'b100000);

    // btnl and btnr together
    set_btns(4'b0101);
    do_reset();
    step(5);
    check("lr_after_E4", outs(), 6'b000000);
    step(1);
    check("lr_after_E5", outs(), 6'b000101);

    // Reset mid-hold of btnd, then re-press after release
    set_btns(4'b1000);
    do_reset();
    step(6);
    check("btnd_rise", outs(), 6'b111000);
    step(2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_clear", outs(), 6'b000000);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(5);
    check("repress_after_E4", outs(), 6'b000000);
    step(1);
    check("repress_after_E5", outs(), 6'b111000);
    step(1);
    check("repress_one_pulse", outs(), 6'b101000);

    // btnr bounce: final stable run starts at E5, rise after E10
    set_btns(4'b0000);
    btnr = pat[0][0];
    do_reset();
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      btnr = pat[i][0];
    end
    step(2);
    check("bounce_after_E9", outs(), 6'b000000);
    step(1);
    check("bounce_after_E10", outs(), 6'b000100);

    // Random button activity with occasional resets
    for (int seg = 0; seg < 400; seg++) begin
      set_btns(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) do_reset();
      step($urandom_range(1, 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_btn_cond.md
CALC_BTN_COND -- requirements
Module: calc_btn_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive clocks a synchronized input must differ from its debounced level before that level changes.
REQ-002 Parameter CNT_W, default 20: width of each debounce counter.
REQ-003 Port clk, input, 1: single clock, rising-edge; one clock; reset is asynchronous and active-low.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Ports btnl, btnc, btnr, btnd, input, 1 each: raw asynchronous push-button levels, active-high.
REQ-006 Ports btnl_db, btnc_db, btnr_db, output, 1 each: debounced levels that drive the downstream ALU-op encoder inputs.
REQ-007 Port btnd_db, output, 1: debounced level of btnd.
REQ-008 Port btnd_pulse, output, 1: one-cycle execute strobe on each debounced btnd press.
REQ-009 Port op_valid, output, 1: high from the first btnd_pulse after reset onward.

Function
REQ-010 Each of the four buttons SHALL pass through its own two-flop synchronizer (s1 then s2) before any other logic.
REQ-011 Each button SHALL have an independent debounce channel (counter plus debounced level); channels SHALL NOT interact.
REQ-012 When s2 equals the debounced level on a clock edge, the channel counter SHALL clear to 0.
REQ-013 When s2 differs from the debounced level on a clock edge, the counter SHALL increment.
REQ-014 The debounced level SHALL toggle, and the counter SHALL clear, on the DEBOUNCE_CYCLES-th consecutive differing edge.
REQ-015 Latency: a raw change set up before edge E0 SHALL appear on the debounced output after edge E(DEBOUNCE_CYCLES+1).
REQ-016 A raw pulse or glitch lasting fewer than DEBOUNCE_CYCLES clocks after synchronization SHALL leave the debounced level unchanged, and the counter SHALL restart from 0.
REQ-017 Counters SHALL NOT wrap; the toggle at REQ-014 always occurs before overflow (DEBOUNCE_CYCLES between 1 and 2^CNT_W-1).
REQ-018 btnd_pulse SHALL be registered and high for exactly one cycle: the same cycle in which btnd_db first reads 1 after being 0.
REQ-019 A held btnd SHALL produce exactly one btnd_pulse; a debounced btnd release SHALL produce no pulse.
REQ-020 A new pulse SHALL require a debounced release followed by a new debounced press.
REQ-021 op_valid SHALL set on the edge that raises btnd_pulse and hold until reset.
REQ-022 Simultaneous changes on several buttons SHALL each debounce independently, with identical latency.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from raw inputs.

Reset
REQ-024 While rst_n=0, all synchronizer flops, counters, debounced levels, btnd_pulse and op_valid SHALL be 0, asynchronously.
REQ-025 Reset asserted mid-count or during btnd_pulse SHALL clear the outputs immediately; no pulse is lost or replayed after release.
REQ-026 After rst_n deasserts, a button already held SHALL be treated as a new press: debounce, then one btnd_pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset, btnl=1 set up before E0 and held -> btnl_db=0 through E4, =1 after E5; other outputs stay 0.
REQ-028 btnc high for 3 clocks, then low -> btnc_db stays 0; the counter returns to 0.
REQ-029 btnd held high 20 clocks, then released -> exactly one btnd_pulse, coincident with btnd_db rise; op_valid=1 afterward and after release.
REQ-030 btnl, btnr rise together on the same cycle -> both debounced outputs rise on the same edge, E5.
REQ-031 rst_n pulsed low two cycles after btnd_db rises, btnd still held -> all outputs 0 at once; after release, btnd_db rises 5 edges later with one new pulse.
REQ-032 Bounce pattern on btnr (1,0,1,1,0,1,1,1,1 per clock) -> btnr_db rises only after the final 4-cycle stable run plus sync latency.
